// File: rtl/empty_ptr_pool_if.sv
// Handshake bundle between the free-address pool and its users.
// master = delete/insert side, slave = the pool itself.
interface empty_ptr_pool_if #(
    parameter int A_WIDTH = 4
);
    logic [A_WIDTH-1:0] add_empty_ptr;
    logic               add_empty_ptr_en;
    logic [A_WIDTH-1:0] next_empty_ptr;
    logic               next_empty_ptr_val;
    logic               next_empty_ptr_ack;

    modport master (
        output add_empty_ptr, add_empty_ptr_en, next_empty_ptr_ack,
        input  next_empty_ptr, next_empty_ptr_val
    );

    modport slave (
        input  add_empty_ptr, add_empty_ptr_en, next_empty_ptr_ack,
        output next_empty_ptr, next_empty_ptr_val
    );
endinterface

// File: rtl/empty_ptr_pool.sv
// Circular free-list of table addresses, self-filled with 0..DEPTH-1 after reset.
// Optional EMPTY_PTR_DOUBLE_FREE_CHECK_EN adds an in-pool bitmap that rejects duplicate frees.
module empty_ptr_pool #(
    parameter int A_WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    empty_ptr_pool_if.slave    pool,
    output logic               init_done_o,
    output logic [A_WIDTH:0]   used_cnt_o,
    output logic               overflow_o,
`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
    output logic               double_free_o,
`endif
    output logic               underflow_o
);
    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0]   CNT_FULL = (A_WIDTH+1)'(DEPTH);
    localparam logic [A_WIDTH-1:0] IDX_LAST = A_WIDTH'(DEPTH - 1);

    typedef enum logic {INIT_S, RUN_S} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_idx, rd_idx, init_cnt, head;
    logic               init_wr, run;
    logic               val, full, pop, push, ovf, dup;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= INIT_S;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT_S && init_cnt == IDX_LAST) state_d = RUN_S;
    end

    always_comb begin
        init_wr = 1'b0;
        run     = 1'b0;
        case (state_q)
            INIT_S:  init_wr = 1'b1;
            RUN_S:   run     = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    assign head = mem[rd_idx];
    assign val  = run && (used_cnt_o != '0);
    assign full = (used_cnt_o == CNT_FULL);
    assign pop  = val && pool.next_empty_ptr_ack;

    // Full-without-pop is reported as overflow before any duplicate check.
    assign ovf  = pool.add_empty_ptr_en && (!run || (full && !pop));

`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
    logic [DEPTH-1:0] in_pool;
    // Popping the same address this cycle makes re-freeing it legal.
    assign dup = pool.add_empty_ptr_en && !ovf && in_pool[pool.add_empty_ptr]
                 && !(pop && head == pool.add_empty_ptr);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_pool       <= '0;
            double_free_o <= 1'b0;
        end else begin
            double_free_o <= dup;
            if (init_wr) begin
                in_pool[init_cnt] <= 1'b1;
            end else begin
                if (pop)  in_pool[head]               <= 1'b0;
                if (push) in_pool[pool.add_empty_ptr] <= 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign push = pool.add_empty_ptr_en && !ovf && !dup;

    assign pool.next_empty_ptr_val = val;
    assign pool.next_empty_ptr     = val ? head : '0;

    always_ff @(posedge clk_i) begin
        if (init_wr)   mem[init_cnt] <= init_cnt;
        else if (push) mem[wr_idx]   <= pool.add_empty_ptr;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            init_cnt    <= '0;
            used_cnt_o  <= '0;
            init_done_o <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            init_done_o <= (state_d == RUN_S);
            overflow_o  <= ovf;
            underflow_o <= pool.next_empty_ptr_ack && !val;
            if (init_wr) begin
                init_cnt <= init_cnt + 1'b1;
                if (state_d == RUN_S) used_cnt_o <= CNT_FULL;
            end else begin
                if (pop)  rd_idx <= rd_idx + 1'b1;
                if (push) wr_idx <= wr_idx + 1'b1;
                if (push && !pop)      used_cnt_o <= used_cnt_o + 1'b1;
                else if (pop && !push) used_cnt_o <= used_cnt_o - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_empty_ptr_pool.sv
// Directed bench for empty_ptr_pool (A_WIDTH=4): vector table plus reset/double-free sequences.
module tb_empty_ptr_pool;
    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          init_done_o, overflow_o, underflow_o;
    logic [AW:0]   used_cnt_o;
`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
    logic          double_free_o;
`endif

    empty_ptr_pool_if #(.A_WIDTH(AW)) pif ();

    empty_ptr_pool #(.A_WIDTH(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pool        (pif.slave),
        .init_done_o (init_done_o),
        .used_cnt_o  (used_cnt_o),
        .overflow_o  (overflow_o),
`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
        .double_free_o(double_free_o),
`endif
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          en;
        logic [AW-1:0] ptr;
        logic          ack;
        logic          exp_val;
        logic [AW-1:0] exp_ptr;
        logic [AW:0]   exp_cnt;
        logic          exp_ovf;
        logic          exp_unf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic en, input int ptr, input logic ack);
        pif.add_empty_ptr_en   = en;
        pif.add_empty_ptr      = AW'(ptr);
        pif.next_empty_ptr_ack = ack;
    endtask

    task automatic add(input logic en, input int ptr, input logic ack, input logic val,
                       input int eptr, input int cnt, input logic ovf, input logic unf);
        vec_t v;
        v.en = en; v.ptr = AW'(ptr); v.ack = ack;
        v.exp_val = val; v.exp_ptr = AW'(eptr); v.exp_cnt = (AW+1)'(cnt);
        v.exp_ovf = ovf; v.exp_unf = unf;
        vecs.push_back(v);
    endtask

    // Reset release, then DEPTH init cycles with val low until the last one.
    task automatic run_init(input string tag, input bit push_mid);
        logic saw_val = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (push_mid && i == 3) drive(1'b1, 9, 1'b0);
            tick();
            if (push_mid && i == 3) begin
                chk({tag, " init push ovf"}, overflow_o, 1'b1);
                drive(1'b0, 0, 1'b0);
            end
            if (i < 16 && (pif.next_empty_ptr_val || init_done_o)) saw_val = 1'b1;
        end
        chk({tag, " val/done during init"}, saw_val, 1'b0);
        chk({tag, " init_done"}, init_done_o, 1'b1);
        chk({tag, " val after init"}, pif.next_empty_ptr_val, 1'b1);
        chk({tag, " used_cnt after init"}, used_cnt_o, 16);
        chk({tag, " head after init"}, pif.next_empty_ptr, 0);
    endtask

    initial begin
        drive(1'b0, 0, 1'b0);

        // ---- reset state ----
        repeat (2) @(negedge clk_i);
        chk("rst val", pif.next_empty_ptr_val, 1'b0);
        chk("rst ptr", pif.next_empty_ptr, 0);
        chk("rst cnt", used_cnt_o, 0);
        chk("rst done", init_done_o, 1'b0);
        chk("rst ovf", overflow_o, 1'b0);
        chk("rst unf", underflow_o, 1'b0);
        rst_i = 1'b0;
        run_init("init1", 1'b0);

        // ---- vector table ----
        add(0, 0, 1, 1, 1, 15, 0, 0);
        add(0, 0, 1, 1, 2, 14, 0, 0);
        add(0, 0, 1, 1, 3, 13, 0, 0);
        add(1, 1, 0, 1, 3, 14, 0, 0);
        for (int k = 0; k < 14; k++) begin
            if (k < 12)       add(0, 0, 1, 1, 4 + k, 13 - k, 0, 0);
            else if (k == 12) add(0, 0, 1, 1, 1, 1, 0, 0);
            else              add(0, 0, 1, 0, 0, 0, 0, 0);
        end
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 7, 1, 1, 7, 1, 0, 1);
        add(0, 0, 0, 1, 7, 1, 0, 0);
        for (int k = 0; k < 15; k++) add(1, (8 + k) % 16, 0, 1, 7, 2 + k, 0, 0);
        add(1, 5, 0, 1, 7, 16, 1, 0);
        add(1, 7, 1, 1, 8, 16, 0, 0);
        add(0, 0, 0, 1, 8, 16, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, int'(vecs[i].ptr), vecs[i].ack);
            tick();
            chk($sformatf("v%0d val", i), pif.next_empty_ptr_val, vecs[i].exp_val);
            chk($sformatf("v%0d ptr", i), pif.next_empty_ptr, vecs[i].exp_ptr);
            chk($sformatf("v%0d cnt", i), used_cnt_o, vecs[i].exp_cnt);
            chk($sformatf("v%0d ovf", i), overflow_o, vecs[i].exp_ovf);
            chk($sformatf("v%0d unf", i), underflow_o, vecs[i].exp_unf);
        end
        drive(1'b0, 0, 1'b0);

        // ---- async reset in the middle of re-initialisation ----
        rst_i = 1'b1;
        #1;
        chk("async rst cnt", used_cnt_o, 0);
        @(negedge clk_i) rst_i = 1'b0;
        repeat (8) tick();
        chk("mid-init val", pif.next_empty_ptr_val, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        chk("mid-init rst done", init_done_o, 1'b0);
        chk("mid-init rst val", pif.next_empty_ptr_val, 1'b0);
        @(negedge clk_i) rst_i = 1'b0;
        run_init("init2", 1'b1);

        // ---- duplicate free after one pop ----
        drive(1'b0, 0, 1'b1);
        tick();
        chk("pop0 head", pif.next_empty_ptr, 1);
        chk("pop0 cnt", used_cnt_o, 15);
        drive(1'b1, 3, 1'b0);
        tick();
        chk("dup push ovf", overflow_o, 1'b0);
`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
        chk("dup push double_free", double_free_o, 1'b1);
        chk("dup push cnt", used_cnt_o, 15);
        drive(1'b1, 0, 1'b0);
        tick();
        chk("refree 0 double_free", double_free_o, 1'b0);
        chk("refree 0 cnt", used_cnt_o, 16);
`else
        chk("dup push cnt", used_cnt_o, 16);
`endif
        drive(1'b0, 0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
